// File: rtl/ksa_pkg.sv
// rtl/ksa_pkg.sv - shared types, constants and baud helper for the decrypt message UART reader
package ksa_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD_ADDR,
    RD_WAIT,
    START_B,
    DATA_B,
    STOP_B,
    DONE
  } tx_state_t;

  localparam logic [7:0] CR = 8'h0D;
  localparam logic [7:0] LF = 8'h0A;

  // Rounded integer divider; no fractional accumulation is done anywhere.
  function automatic int baud_div(input int clk_hz, input int baud);
    return (clk_hz + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// rtl/uart_tx_byte.sv - 8N1 byte serialiser: baud counter, shift register and bit counter
module uart_tx_byte #(
  parameter int BAUD_DIV = 434
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       load,
  input  logic [7:0] data,
  output logic       tx,
  output logic       frame_done,
  output logic       bit_end,
  output logic [3:0] bit_idx
);

  localparam int CNT_W = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(BAUD_DIV - 1);

  logic             active_q, active_d;
  logic [CNT_W-1:0] baud_q, baud_d;
  logic [3:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;
  logic             tx_q, tx_d;

  // bit_q: 0 = start bit, 1..8 = data bits LSB first, 9 = stop bit.
  assign bit_end    = active_q && (baud_q == BAUD_LAST);
  assign frame_done = bit_end && (bit_q == 4'd9);
  assign bit_idx    = bit_q;
  assign tx         = tx_q;

  always_comb begin
    active_d = active_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    tx_d     = tx_q;
    if (load) begin
      active_d = 1'b1;
      baud_d   = '0;
      bit_d    = 4'd0;
      shift_d  = data;
      tx_d     = 1'b0;
    end else if (active_q) begin
      if (bit_end) begin
        baud_d = '0;
        if (bit_q == 4'd9) begin
          active_d = 1'b0;
          tx_d     = 1'b1;
        end else begin
          bit_d = bit_q + 4'd1;
          if (bit_q < 4'd8) begin
            tx_d    = shift_q[0];
            shift_d = {1'b0, shift_q[7:1]};
          end else begin
            tx_d = 1'b1;
          end
        end
      end else begin
        baud_d = baud_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      active_q <= 1'b0;
      baud_q   <= '0;
      bit_q    <= 4'd0;
      shift_q  <= 8'd0;
      tx_q     <= 1'b1;
    end else begin
      active_q <= active_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      tx_q     <= tx_d;
    end
  end

endmodule

// File: rtl/decrypt_msg_uart_tx.sv
// rtl/decrypt_msg_uart_tx.sv - reads MSG_LEN decrypted bytes and sends them 8N1 on tx
// Optional MSG_TX_CRLF_EN appends CR, LF frames after the last message byte.
module decrypt_msg_uart_tx
  import ksa_pkg::*;
#(
  parameter int CLK_HZ   = 50_000_000,
  parameter int BAUD     = 115200,
  parameter int MSG_LEN  = 32,
  parameter int ADDR_W   = 5,
  parameter int READ_LAT = 2,
  parameter int BAUD_DIV = baud_div(CLK_HZ, BAUD)
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  output logic [ADDR_W-1:0] mem_address,
  input  logic [7:0]        mem_q,
  output logic              tx,
  output logic              busy,
  output logic              done
);

  localparam int WAIT_W = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(READ_LAT - 1);
  localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(MSG_LEN - 1);

  tx_state_t         state_q, state_d;
  logic [ADDR_W-1:0] byte_idx_q, byte_idx_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              busy_q, done_q;
  logic              load;
  logic [7:0]        load_data;
  logic              frame_done, bit_end;
  logic [3:0]        bit_idx;
`ifdef MSG_TX_CRLF_EN
  logic [1:0]        crlf_q, crlf_d;
`endif

  uart_tx_byte #(
    .BAUD_DIV(BAUD_DIV)
  ) u_ser (
    .clock      (clock),
    .reset_n    (reset_n),
    .load       (load),
    .data       (load_data),
    .tx         (tx),
    .frame_done (frame_done),
    .bit_end    (bit_end),
    .bit_idx    (bit_idx)
  );

  assign mem_address = byte_idx_q;
  assign busy        = busy_q;
  assign done        = done_q;

  always_comb begin
    state_d    = state_q;
    byte_idx_d = byte_idx_q;
    wait_d     = wait_q;
    load       = 1'b0;
    load_data  = mem_q;
`ifdef MSG_TX_CRLF_EN
    crlf_d     = crlf_q;
`endif
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d    = RD_ADDR;
          byte_idx_d = '0;
`ifdef MSG_TX_CRLF_EN
          crlf_d     = 2'd0;
`endif
        end
      end
      RD_ADDR: begin
        state_d = RD_WAIT;
        wait_d  = '0;
      end
      RD_WAIT: begin
        if (wait_q == WAIT_LAST) begin
          load    = 1'b1;
          state_d = START_B;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      START_B: begin
        if (bit_end) state_d = DATA_B;
      end
      DATA_B: begin
        if (bit_end && bit_idx == 4'd8) state_d = STOP_B;
      end
      STOP_B: begin
        if (frame_done) begin
          if (byte_idx_q != LAST_IDX) begin
            byte_idx_d = byte_idx_q + 1'b1;
            state_d    = RD_ADDR;
          end else begin
`ifdef MSG_TX_CRLF_EN
            // Trailer bytes are constants, so they are loaded straight from the stop bit.
            if (crlf_q == 2'd0) begin
              load      = 1'b1;
              load_data = CR;
              crlf_d    = 2'd1;
              state_d   = START_B;
            end else if (crlf_q == 2'd1) begin
              load      = 1'b1;
              load_data = LF;
              crlf_d    = 2'd2;
              state_d   = START_B;
            end else begin
              state_d = DONE;
            end
`else
            state_d = DONE;
`endif
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      byte_idx_q <= '0;
      wait_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
`ifdef MSG_TX_CRLF_EN
      crlf_q     <= 2'd0;
`endif
    end else begin
      state_q    <= state_d;
      byte_idx_q <= byte_idx_d;
      wait_q     <= wait_d;
      busy_q     <= !(state_d == IDLE || state_d == DONE);
      done_q     <= (state_d == DONE);
`ifdef MSG_TX_CRLF_EN
      crlf_q     <= crlf_d;
`endif
    end
  end

endmodule

// File: tb/tb_decrypt_msg_uart_tx.sv
// tb/tb_decrypt_msg_uart_tx.sv - line-decoding bench for decrypt_msg_uart_tx
module tb_decrypt_msg_uart_tx;

  localparam int MSG_LEN  = 32;
  localparam int ADDR_W   = 5;
  localparam int READ_LAT = 2;
  localparam int BD       = 4;
  localparam int FRAME    = 10 * BD;
  localparam int GAP      = 1 + READ_LAT;
`ifdef MSG_TX_CRLF_EN
  localparam int NFR = MSG_LEN + 2;
`else
  localparam int NFR = MSG_LEN;
`endif
  localparam int FIRST_START = GAP + 1;
  localparam int LAST_STOP = FIRST_START + (FRAME + GAP) * (MSG_LEN - 1) + FRAME - 1
                             + (NFR - MSG_LEN) * FRAME;

  logic              clock = 1'b0;
  logic              reset_n = 1'b0;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] mem_address;
  logic [7:0]        mem_q;
  logic              tx, busy, done;

  logic [7:0] mem [MSG_LEN];
  logic [7:0] p1, p2;
  logic [7:0] exp_b [$];
  logic       samp_q [$];
  logic [ADDR_W-1:0] addr_q [$];
  bit         cap = 1'b0;
  int         passed = 0, failed = 0, total = 0;

  decrypt_msg_uart_tx #(
    .CLK_HZ(400), .BAUD(100), .MSG_LEN(MSG_LEN), .ADDR_W(ADDR_W), .READ_LAT(READ_LAT)
  ) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .mem_address(mem_address),
    .mem_q(mem_q), .tx(tx), .busy(busy), .done(done)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    p1 <= mem[mem_address];
    p2 <= p1;
  end
  assign mem_q = p2;

  always @(negedge clock) begin
    if (cap) begin
      samp_q.push_back(tx);
      addr_q.push_back(mem_address);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic decode_check(input string tag);
    int i, nf, bad_t, bad_f, bad_g, gap, eg;
    logic [9:0] bits;
    i = 0; nf = 0; bad_t = 0; bad_f = 0; bad_g = 0; gap = 0;
    while (i < samp_q.size()) begin
      if (samp_q[i] === 1'b1) begin
        gap++;
        i++;
      end else if (i + FRAME > samp_q.size()) begin
        break;
      end else begin
        for (int k = 0; k < 10; k++) begin
          bits[k] = samp_q[i + k * BD];
          for (int j = 1; j < BD; j++)
            if (samp_q[i + k * BD + j] !== bits[k]) bad_t++;
        end
        if (bits[0] !== 1'b0 || bits[9] !== 1'b1) bad_f++;
        if (nf > 0) begin
          eg = (nf < MSG_LEN) ? GAP : 0;
          if (gap != eg) bad_g++;
        end
        if (nf < NFR) begin
          chk($sformatf("%s byte%0d", tag, nf), 32'(bits[8:1]), 32'(exp_b[nf]));
          chk($sformatf("%s addr%0d", tag, nf), 32'(addr_q[i]),
              (nf < MSG_LEN) ? nf : MSG_LEN - 1);
        end
        nf++;
        gap = 0;
        i += FRAME;
      end
    end
    chk({tag, " frames"}, nf, NFR);
    chk({tag, " bit_timing_errs"}, bad_t, 0);
    chk({tag, " framing_errs"}, bad_f, 0);
    chk({tag, " gap_errs"}, bad_g, 0);
  endtask

  task automatic run_msg(input string tag, input bit glitch);
    int c;
    bit got;
    exp_b.delete();
    for (int i = 0; i < MSG_LEN; i++) exp_b.push_back(mem[i]);
`ifdef MSG_TX_CRLF_EN
    exp_b.push_back(8'h0D);
    exp_b.push_back(8'h0A);
`endif
    samp_q.delete();
    addr_q.delete();
    cap = 1'b1;
    @(posedge clock); #1 start = 1'b1;
    @(posedge clock); #1 start = 1'b0;
    c = 0;
    got = 1'b0;
    while (!got && c < LAST_STOP + 200) begin
      @(negedge clock);
      c++;
      if (c == 1) begin
        chk({tag, " busy_after_start"}, 32'(busy), 1);
        chk({tag, " done_after_start"}, 32'(done), 0);
      end
      if (c == LAST_STOP / 2) chk({tag, " done_mid"}, 32'(done), 0);
      if (glitch) begin
        if (c == FIRST_START + (FRAME + GAP) * 3 + 10 ||
            c == FIRST_START + (FRAME + GAP) * (MSG_LEN - 1) + 10 ||
            c == LAST_STOP)
          start = 1'b1;
        else
          start = 1'b0;
      end
      if (done === 1'b1) begin
        got = 1'b1;
        chk({tag, " done_cycle"}, c, LAST_STOP + 1);
      end
    end
    start = 1'b0;
    @(negedge clock);
    cap = 1'b0;
    chk({tag, " done_reached"}, 32'(got), 1);
    chk({tag, " busy_at_end"}, 32'(busy), 0);
    decode_check(tag);
  endtask

  initial begin
    repeat (10) @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    chk("reset tx", 32'(tx), 1);
    chk("reset busy", 32'(busy), 0);
    chk("reset done", 32'(done), 0);
    chk("reset addr", 32'(mem_address), 0);

    for (int i = 0; i < MSG_LEN; i++) mem[i] = 8'h00;
    mem[0] = 8'h48; mem[1] = 8'h65; mem[2] = 8'h6C; mem[3] = 8'h6C; mem[4] = 8'h6F;
    run_msg("hello", 1'b0);

    for (int i = 0; i < MSG_LEN; i++) mem[i] = 8'($urandom);
    mem[0] = 8'hA5;
    run_msg("glitch", 1'b1);
    chk("late_start done_held", 32'(done), 1);
    chk("late_start busy_low", 32'(busy), 0);

    for (int i = 0; i < MSG_LEN; i++) mem[i] = 8'($urandom);
    run_msg("second", 1'b0);

    for (int i = 0; i < MSG_LEN; i++) mem[i] = 8'($urandom);
    mem[7] = 8'h00;
    @(posedge clock); #1 start = 1'b1;
    @(posedge clock); #1 start = 1'b0;
    for (int c = 1; c <= FIRST_START + (FRAME + GAP) * 7 + 15; c++) @(negedge clock);
    chk("abort pre_reset tx", 32'(tx), 0);
    chk("abort pre_reset busy", 32'(busy), 1);
    #2 reset_n = 1'b0;
    #1;
    chk("abort tx", 32'(tx), 1);
    chk("abort busy", 32'(busy), 0);
    chk("abort done", 32'(done), 0);
    chk("abort addr", 32'(mem_address), 0);
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    repeat (2) @(negedge clock);
    chk("abort idle tx", 32'(tx), 1);

    for (int i = 0; i < MSG_LEN; i++) mem[i] = 8'($urandom);
    run_msg("resend", 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
